// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches and queues {pc, instr} for decode.
// Optional FETCH_PERF_CNT_EN macro adds perf_fetch_cnt / perf_discard_cnt outputs.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_discard_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = CW + 1;

  logic [31:0]   r_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW-1:0] r_fHead;
  logic [AW-1:0] r_fTail;

  logic [31:0] r_qPc    [DEPTH];
  logic [31:0] r_qInstr [DEPTH];
  logic [31:0] r_fPc    [DEPTH];

  logic          w_pop;
  logic          w_accept;
  logic          w_rspKeep;
  logic          w_rspDrop;
  logic          w_credit;
  logic [SW-1:0] w_inUse;
  logic [31:0]   w_target;

  assign w_target  = redirect_pc & 32'hFFFF_FFFC;
  assign if_valid  = (r_count != '0);
  assign if_pc     = if_valid ? r_qPc[r_head]    : 32'h0;
  assign if_instr  = if_valid ? r_qInstr[r_head] : 32'h0;
  assign w_pop     = if_valid & if_ready;

  // Every request slot is either in flight or holding a queued word, so a pop frees one.
  assign w_inUse   = SW'(r_outstanding) + SW'(r_count) - SW'(w_pop);
  assign w_credit  = (w_inUse < SW'(DEPTH));

  assign imem_req_valid = !reset && !redirect_valid && w_credit;
  assign imem_addr      = r_pc;
  assign w_accept       = imem_req_valid & imem_req_ready;

  assign w_rspKeep = imem_rsp_valid && !redirect_valid && (r_discard == '0);
  assign w_rspDrop = imem_rsp_valid && (redirect_valid || (r_discard != '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_fHead       <= '0;
      r_fTail       <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight after this cycle is stale; a response arriving now is dropped here.
      r_pc          <= w_target;
      r_count       <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_fHead       <= '0;
      r_fTail       <= '0;
      r_outstanding <= r_outstanding - CW'(imem_rsp_valid);
      r_discard     <= r_outstanding - CW'(imem_rsp_valid);
    end else begin
      if (w_accept) begin
        r_pc    <= r_pc + 32'd4;
        r_fTail <= r_fTail + 1'b1;
      end
      if (imem_rsp_valid) begin
        if (r_discard != '0) begin
          r_discard <= r_discard - 1'b1;
        end else begin
          r_tail  <= r_tail + 1'b1;
          r_fHead <= r_fHead + 1'b1;
        end
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      r_count       <= r_count + CW'(w_rspKeep) - CW'(w_pop);
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(imem_rsp_valid);
    end
  end

  // Storage needs no reset: head/tail/count decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_fPc[r_fTail] <= r_pc;
    end
    if (w_rspKeep) begin
      r_qPc[r_tail]    <= r_fPc[r_fHead];
      r_qInstr[r_tail] <= imem_rsp_data;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt   <= 32'h0;
      perf_discard_cnt <= 32'h0;
    end else begin
      if (w_pop) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (w_rspDrop) begin
        perf_discard_cnt <= perf_discard_cnt + 32'd1;
      end
    end
  end
`else
  logic w_unusedDrop;
  assign w_unusedDrop = w_rspDrop;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven streaming/stall vectors plus redirect and wrap sequences.
// Builds with or without FETCH_PERF_CNT_EN.
module tb_fetch_unit;

  localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_discard_cnt;
`endif

  int nTests = 0;
  int nFail  = 0;
  int memLat = 1;

  logic        pipeV [3];
  logic [31:0] pipeD [3];

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt   (perf_fetch_cnt),
    .perf_discard_cnt (perf_discard_cnt)
`endif
  );

  always #5 clk = ~clk;

  // In-order memory with memLat cycles of latency; data is the address xor a fixed key.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        pipeV[i] <= 1'b0;
        pipeD[i] <= 32'h0;
      end
    end else begin
      pipeV[0] <= imem_req_valid && imem_req_ready;
      pipeD[0] <= imem_addr ^ XOR_KEY;
      for (int i = 1; i < 3; i++) begin
        pipeV[i] <= pipeV[i-1];
        pipeD[i] <= pipeD[i-1];
      end
    end
  end

  assign imem_rsp_valid = pipeV[memLat-1];
  assign imem_rsp_data  = pipeD[memLat-1];

  typedef struct {
    logic        rdy;
    logic        expValid;
    logic [31:0] expPc;
    logic        expReq;
    logic [31:0] expAddr;
  } vec_t;

  vec_t vecs [13];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nTests++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] rpc);
    if_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic doReset(input int lat);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    memLat = lat;
    checkOutput("reset if_valid", {31'h0, if_valid}, 32'h0);
    checkOutput("reset if_pc", if_pc, 32'h0);
    checkOutput("reset if_instr", if_instr, 32'h0);
    checkOutput("reset req_valid", {31'h0, imem_req_valid}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("reset perf_fetch", perf_fetch_cnt, 32'h0);
    checkOutput("reset perf_discard", perf_discard_cnt, 32'h0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits (bounded) for the next valid entry with if_ready high and checks it; the entry pops on the next edge.
  task automatic collectNext(input logic [31:0] expPc, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (if_valid) begin
        checkOutput({name, " pc"}, if_pc, expPc);
        checkOutput({name, " instr"}, if_instr, expPc ^ XOR_KEY);
        found = 1'b1;
      end
      @(negedge clk);
      #1;
    end
    if (!found) begin
      nTests++;
      nFail++;
      $display("[TB] FAIL %s timeout: got no if_valid, expected pc %h", name, expPc);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[1]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h04};
    vecs[2]  = '{1'b1, 1'b1, 32'h00, 1'b1, 32'h08};
    vecs[3]  = '{1'b1, 1'b1, 32'h04, 1'b1, 32'h0C};
    vecs[4]  = '{1'b0, 1'b1, 32'h08, 1'b0, 32'h10};
    vecs[5]  = '{1'b0, 1'b1, 32'h08, 1'b0, 32'h10};
    vecs[6]  = '{1'b0, 1'b1, 32'h08, 1'b0, 32'h10};
    vecs[7]  = '{1'b0, 1'b1, 32'h08, 1'b0, 32'h10};
    vecs[8]  = '{1'b0, 1'b1, 32'h08, 1'b0, 32'h10};
    vecs[9]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h10};
    vecs[10] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h14};
    vecs[11] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h18};
    vecs[12] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h1C};

    // Streaming with 1-cycle memory, then a 5-cycle stall at pc 0x8 and resume.
    doReset(1);
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].rdy, 1'b0, 32'h0);
      checkOutput($sformatf("v%0d if_valid", i), {31'h0, if_valid}, {31'h0, vecs[i].expValid});
      if (vecs[i].expValid) begin
        checkOutput($sformatf("v%0d if_pc", i), if_pc, vecs[i].expPc);
        checkOutput($sformatf("v%0d if_instr", i), if_instr, vecs[i].expPc ^ XOR_KEY);
      end
      checkOutput($sformatf("v%0d req_valid", i), {31'h0, imem_req_valid}, {31'h0, vecs[i].expReq});
      checkOutput($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].expAddr);
      @(negedge clk);
    end

    // Mid-run reset, 3-cycle memory, redirect to 0x103 with two requests in flight.
    doReset(3);
    applyStimulus(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 32'h0000_0103);
    checkOutput("redir3 req_valid forced low", {31'h0, imem_req_valid}, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("redir3 if_valid", {31'h0, if_valid}, 32'h0);
    checkOutput("redir3 target addr", imem_addr, 32'h0000_0100);
    for (int i = 0; i < 10; i++) begin
      collectNext(32'h0000_0100 + 32'(4 * i), $sformatf("lat3 word%0d", i));
    end
    applyStimulus(1'b0, 1'b0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("perf_fetch_cnt", perf_fetch_cnt, 32'd10);
    checkOutput("perf_discard_cnt", perf_discard_cnt, 32'd2);
`endif

    // Redirect coinciding with a response and a pop.
    doReset(1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      @(negedge clk);
    end
    applyStimulus(1'b1, 1'b1, 32'h0000_0200);
    checkOutput("same-cycle pre if_pc", if_pc, 32'h4);
    checkOutput("same-cycle req_valid forced low", {31'h0, imem_req_valid}, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("same-cycle if_valid", {31'h0, if_valid}, 32'h0);
    checkOutput("same-cycle target addr", imem_addr, 32'h0000_0200);
    checkOutput("same-cycle req_valid", {31'h0, imem_req_valid}, 32'h1);
    collectNext(32'h0000_0200, "same-cycle first");
    collectNext(32'h0000_0204, "same-cycle second");

    // PC wrap past the top of the address space, target low bits ignored.
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFB);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("wrap target addr", imem_addr, 32'hFFFF_FFF8);
    collectNext(32'hFFFF_FFF8, "wrap0");
    collectNext(32'hFFFF_FFFC, "wrap1");
    collectNext(32'h0000_0000, "wrap2");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
